// File: rtl/mem_access_ctrl_pkg.sv
// Shared bus definitions for the MEM-stage access controller: widths, FSM
// states, byte-lane select codes and the latched request payload.
package mem_access_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DONE   = 3'd3,
        ST_CANCEL = 3'd4
    } state_t;

    localparam logic [SEL_W-1:0] SEL_B0   = 4'b0001;
    localparam logic [SEL_W-1:0] SEL_B1   = 4'b0010;
    localparam logic [SEL_W-1:0] SEL_B2   = 4'b0100;
    localparam logic [SEL_W-1:0] SEL_B3   = 4'b1000;
    localparam logic [SEL_W-1:0] SEL_H0   = 4'b0011;
    localparam logic [SEL_W-1:0] SEL_H1   = 4'b1100;
    localparam logic [SEL_W-1:0] SEL_WORD = 4'b1111;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] wdata;
        logic              wr;
        logic              sign_ext;
    } acc_req_t;

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Load alignment: shifts the bus word down to the addressed lane, then
// sign/zero-extends byte and halfword loads.
module load_extend
    import mem_access_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        offset,
    input  logic [SEL_W-1:0]  sel,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] ext_c
);

    logic [DATA_W-1:0] shifted;
    logic              fill_b;
    logic              fill_h;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        fill_b  = sign_ext & shifted[7];
        fill_h  = sign_ext & shifted[15];
        ext_c   = shifted;
        case (sel)
            SEL_B0, SEL_B1, SEL_B2, SEL_B3: ext_c = {{24{fill_b}}, shifted[7:0]};
            SEL_H0, SEL_H1:                 ext_c = {{16{fill_h}}, shifted[15:0]};
            default:                        ext_c = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access controller: issues one bus handshake per
// load/store, stalls the pipeline while it is outstanding, and aligns load data.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_current_stage,
    input  logic              flush,
    input  logic              mem_read_flag,
    input  logic              mem_write_flag,
    input  logic              mem_sign_ext_flag,
    input  logic [SEL_W-1:0]  mem_sel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_write_data,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [SEL_W-1:0]  bus_be,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              stall_request,
    output logic              load_valid,
    output logic [DATA_W-1:0] load_data
);

    state_t            state;
    acc_req_t          req_q;
    acc_req_t          new_req;
    logic [DATA_W-1:0] rdata_q;
    logic              access;

    assign access = (mem_read_flag | mem_write_flag) & ~flush;

    // Request as seen on the EX/MEM register this cycle; reads never carry write data.
    always_comb begin
        new_req          = '0;
        new_req.addr     = mem_addr;
        new_req.sel      = mem_sel;
        new_req.wdata    = mem_write_flag ? mem_write_data : '0;
        new_req.wr       = mem_write_flag;
        new_req.sign_ext = mem_sign_ext_flag;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            req_q      <= '0;
            rdata_q    <= '0;
            bus_req    <= 1'b0;
            bus_wr     <= 1'b0;
            load_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    load_valid <= 1'b0;
                    if (access) begin
                        req_q   <= new_req;
                        bus_req <= 1'b1;
                        bus_wr  <= new_req.wr;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus_addr_ok) begin
                        bus_req <= 1'b0;
                        bus_wr  <= 1'b0;
                        if (flush) begin
                            // Data already returned alongside the flush: nothing left to drain.
                            state <= bus_data_ok ? ST_IDLE : ST_CANCEL;
                        end else if (bus_data_ok) begin
                            rdata_q    <= bus_rdata;
                            load_valid <= ~req_q.wr;
                            state      <= ST_DONE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end else if (flush) begin
                        bus_req <= 1'b0;
                        bus_wr  <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        state <= bus_data_ok ? ST_IDLE : ST_CANCEL;
                    end else if (bus_data_ok) begin
                        rdata_q    <= bus_rdata;
                        load_valid <= ~req_q.wr;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (flush || !stall_current_stage) begin
                        load_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                ST_CANCEL: begin
                    // Stale data is dropped; a waiting access is issued straight away.
                    if (bus_data_ok) begin
                        if (access) begin
                            req_q   <= new_req;
                            bus_req <= 1'b1;
                            bus_wr  <= new_req.wr;
                            state   <= ST_REQ;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    bus_req    <= 1'b0;
                    bus_wr     <= 1'b0;
                    load_valid <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_be    = req_q.sel;
    assign bus_addr  = req_q.addr;
    assign bus_wdata = req_q.wdata;

    // Combinational so the pipeline is held in the same cycle the access appears.
    assign stall_request = rst & (((state == ST_IDLE) & access) |
                                  (state == ST_REQ) | (state == ST_WAIT) |
                                  ((state == ST_CANCEL) & access));

    load_extend u_load_extend (
        .word     (rdata_q),
        .offset   (req_q.addr[1:0]),
        .sel      (req_q.sel),
        .sign_ext (req_q.sign_ext),
        .ext_c    (load_data)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: the bench plays the bus slave cycle by
// cycle and checks every output against hand-computed values.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_current_stage;
    logic        flush;
    logic        mem_read_flag;
    logic        mem_write_flag;
    logic        mem_sign_ext_flag;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        stall_request;
    logic        load_valid;
    logic [31:0] load_data;

    int tests = 0;
    int fails = 0;
    int req_cycles;

    mem_access_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall_current_stage (stall_current_stage),
        .flush               (flush),
        .mem_read_flag       (mem_read_flag),
        .mem_write_flag      (mem_write_flag),
        .mem_sign_ext_flag   (mem_sign_ext_flag),
        .mem_sel             (mem_sel),
        .mem_addr            (mem_addr),
        .mem_write_data      (mem_write_data),
        .bus_req             (bus_req),
        .bus_wr              (bus_wr),
        .bus_be              (bus_be),
        .bus_addr            (bus_addr),
        .bus_wdata           (bus_wdata),
        .bus_addr_ok         (bus_addr_ok),
        .bus_data_ok         (bus_data_ok),
        .bus_rdata           (bus_rdata),
        .stall_request       (stall_request),
        .load_valid          (load_valid),
        .load_data           (load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Minimum-latency load: issue, addr_ok+data_ok in cycle 1, check data in cycle 2.
    task automatic load_min(input string tag, input logic [31:0] addr, input logic [3:0] sel,
                            input logic sext, input logic [31:0] rdata, input logic [31:0] exp);
        mem_read_flag = 1'b1; mem_addr = addr; mem_sel = sel; mem_sign_ext_flag = sext;
        stall_current_stage = 1'b0;
        cyc();
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = rdata;
        cyc();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
        #1;
        chk({tag, "_valid"}, 32'(load_valid), 32'd1);
        chk({tag, "_data"}, load_data, exp);
        cyc();
        mem_read_flag = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b0; stall_current_stage = 1'b0; flush = 1'b0;
        mem_read_flag = 1'b0; mem_write_flag = 1'b0; mem_sign_ext_flag = 1'b0;
        mem_sel = 4'b0; mem_addr = 32'h0; mem_write_data = 32'h0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;

        // Reset: outputs zero even with an access on the inputs
        repeat (2) cyc();
        mem_read_flag = 1'b1; mem_addr = 32'h1234; mem_sel = 4'b1111;
        #1;
        chk("rst_stall", 32'(stall_request), 32'd0);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_be", 32'(bus_be), 32'h0);
        chk("rst_ld", load_data, 32'h0);
        chk("rst_lv", 32'(load_valid), 32'd0);
        mem_read_flag = 1'b0;
        rst = 1'b1;
        cyc();

        // Word load, minimum latency
        mem_read_flag = 1'b1; mem_addr = 32'h0000_1000; mem_sel = 4'b1111; mem_sign_ext_flag = 1'b0;
        #1;
        chk("w_c0_stall", 32'(stall_request), 32'd1);
        chk("w_c0_req", 32'(bus_req), 32'd0);
        cyc();
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        #1;
        chk("w_c1_req", 32'(bus_req), 32'd1);
        chk("w_c1_addr", bus_addr, 32'h0000_1000);
        chk("w_c1_be", 32'(bus_be), 32'hF);
        chk("w_c1_wr", 32'(bus_wr), 32'd0);
        chk("w_c1_wdata", bus_wdata, 32'h0);
        chk("w_c1_stall", 32'(stall_request), 32'd1);
        cyc();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
        #1;
        chk("w_c2_lv", 32'(load_valid), 32'd1);
        chk("w_c2_ld", load_data, 32'hDEAD_BEEF);
        chk("w_c2_stall", 32'(stall_request), 32'd0);
        chk("w_c2_req", 32'(bus_req), 32'd0);
        cyc();
        mem_read_flag = 1'b0;
        #1;
        chk("w_c3_lv", 32'(load_valid), 32'd0);
        chk("w_c3_stall", 32'(stall_request), 32'd0);

        // Alignment and extension
        load_min("sb3", 32'h0000_2003, 4'b1000, 1'b1, 32'h8012_3456, 32'hFFFF_FF80);
        load_min("ub3", 32'h0000_2003, 4'b1000, 1'b0, 32'h8012_3456, 32'h0000_0080);
        load_min("sh2", 32'h0000_2002, 4'b1100, 1'b1, 32'h8001_1234, 32'hFFFF_8001);
        load_min("uh0", 32'h0000_2000, 4'b0011, 1'b0, 32'h1234_ABCD, 32'h0000_ABCD);
        load_min("sb1", 32'h0000_2001, 4'b0010, 1'b1, 32'h0000_7F00, 32'h0000_007F);

        // Halfword store with addr_ok delayed 3 cycles
        mem_write_flag = 1'b1; mem_addr = 32'h0000_3002; mem_sel = 4'b1100;
        mem_write_data = 32'hBEEF_0000;
        #1;
        chk("st_c0_stall", 32'(stall_request), 32'd1);
        cyc();
        for (int i = 0; i < 4; i++) begin
            bus_addr_ok = (i == 3);
            #1;
            chk("st_req", 32'(bus_req), 32'd1);
            chk("st_wr", 32'(bus_wr), 32'd1);
            chk("st_be", 32'(bus_be), 32'hC);
            chk("st_addr", bus_addr, 32'h0000_3002);
            chk("st_wdata", bus_wdata, 32'hBEEF_0000);
            chk("st_lv", 32'(load_valid), 32'd0);
            cyc();
        end
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
        #1;
        chk("st_wait_req", 32'(bus_req), 32'd0);
        chk("st_wait_stall", 32'(stall_request), 32'd1);
        cyc();
        bus_data_ok = 1'b0;
        #1;
        chk("st_done_lv", 32'(load_valid), 32'd0);
        chk("st_done_stall", 32'(stall_request), 32'd0);
        cyc();
        mem_write_flag = 1'b0;
        #1;

        // Flush in WAIT, drained in CANCEL, new load follows immediately
        mem_read_flag = 1'b1; mem_addr = 32'h0000_4000; mem_sel = 4'b1111;
        cyc();
        bus_addr_ok = 1'b1;
        cyc();
        bus_addr_ok = 1'b0; flush = 1'b1;
        #1;
        chk("fl_wait_stall", 32'(stall_request), 32'd1);
        cyc();
        flush = 1'b0; mem_addr = 32'h0000_5000;
        #1;
        chk("fl_cancel_stall", 32'(stall_request), 32'd1);
        chk("fl_cancel_req", 32'(bus_req), 32'd0);
        cyc();
        bus_data_ok = 1'b1; bus_rdata = 32'h1111_1111;
        #1;
        chk("fl_cancel2_stall", 32'(stall_request), 32'd1);
        cyc();
        bus_data_ok = 1'b0;
        #1;
        chk("fl_new_req", 32'(bus_req), 32'd1);
        chk("fl_new_addr", bus_addr, 32'h0000_5000);
        chk("fl_new_lv", 32'(load_valid), 32'd0);
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h2222_2222;
        cyc();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        #1;
        chk("fl_new_lv2", 32'(load_valid), 32'd1);
        chk("fl_new_ld", load_data, 32'h2222_2222);
        cyc();
        mem_read_flag = 1'b0;
        #1;

        // DONE held by stall_current_stage for 5 cycles
        req_cycles = 0;
        mem_read_flag = 1'b1; mem_addr = 32'h0000_6000; mem_sel = 4'b1111;
        stall_current_stage = 1'b1;
        cyc();
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
        #1;
        if (bus_req) req_cycles++;
        cyc();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_rdata = $urandom;
            #1;
            if (bus_req) req_cycles++;
            chk("hold_lv", 32'(load_valid), 32'd1);
            chk("hold_ld", load_data, 32'hCAFE_F00D);
            chk("hold_stall", 32'(stall_request), 32'd0);
            cyc();
        end
        stall_current_stage = 1'b0;
        #1;
        chk("hold_lv_last", 32'(load_valid), 32'd1);
        cyc();
        mem_read_flag = 1'b0;
        #1;
        if (bus_req) req_cycles++;
        chk("hold_exit_lv", 32'(load_valid), 32'd0);
        chk("hold_handshakes", 32'(req_cycles), 32'd1);

        // Flush in REQ before addr_ok
        mem_read_flag = 1'b1; mem_addr = 32'h0000_7000;
        cyc();
        flush = 1'b1;
        #1;
        chk("flreq_req", 32'(bus_req), 32'd1);
        cyc();
        flush = 1'b0; mem_read_flag = 1'b0;
        #1;
        chk("flreq_drop", 32'(bus_req), 32'd0);
        chk("flreq_stall", 32'(stall_request), 32'd0);

        // Flush in IDLE: no access
        mem_read_flag = 1'b1; flush = 1'b1;
        #1;
        chk("flidle_stall", 32'(stall_request), 32'd0);
        cyc();
        #1;
        chk("flidle_req", 32'(bus_req), 32'd0);
        flush = 1'b0; mem_read_flag = 1'b0;
        #1;

        // Flush with addr_ok in REQ, no new access: CANCEL does not stall
        mem_read_flag = 1'b1; mem_addr = 32'h0000_9000;
        cyc();
        bus_addr_ok = 1'b1; flush = 1'b1;
        cyc();
        bus_addr_ok = 1'b0; flush = 1'b0; mem_read_flag = 1'b0;
        #1;
        chk("flack_stall", 32'(stall_request), 32'd0);
        chk("flack_req", 32'(bus_req), 32'd0);
        bus_data_ok = 1'b1; bus_rdata = 32'h3333_3333;
        cyc();
        bus_data_ok = 1'b0;
        #1;
        chk("flack_lv", 32'(load_valid), 32'd0);

        // Asynchronous reset in REQ
        mem_read_flag = 1'b1; mem_addr = 32'h0000_8000; mem_sel = 4'b1111;
        cyc();
        #1;
        chk("ar_req_pre", 32'(bus_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("ar_req", 32'(bus_req), 32'd0);
        chk("ar_addr", bus_addr, 32'h0);
        chk("ar_be", 32'(bus_be), 32'h0);
        chk("ar_stall", 32'(stall_request), 32'd0);
        chk("ar_ld", load_data, 32'h0);
        chk("ar_lv", 32'(load_valid), 32'd0);
        mem_read_flag = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        #1;
        chk("ar_idle_req", 32'(bus_req), 32'd0);
        mem_read_flag = 1'b1; mem_addr = 32'h0000_8004;
        #1;
        chk("ar_idle_stall", 32'(stall_request), 32'd1);
        cyc();
        #1;
        chk("ar_reissue_req", 32'(bus_req), 32'd1);
        chk("ar_reissue_addr", bus_addr, 32'h0000_8004);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port stall_current_stage  in  1  MEM stage held by the stall controller.
REQ-004 SHALL have port flush  in  1  exception flush; cancels the current access.
REQ-005 SHALL have ports mem_read_flag, mem_write_flag, mem_sign_ext_flag  in  1 each  access type from the EX/MEM register.
REQ-006 SHALL have port mem_sel  in  4  byte lanes: 0001/0010/0100/1000 byte, 0011/1100 half, 1111 word.
REQ-007 SHALL have ports mem_addr, mem_write_data  in  32 each  address; lane-aligned store data.
REQ-008 SHALL have ports bus_req, bus_wr  out  1 each  request and write strobe.
REQ-009 SHALL have ports bus_be  out  4, and bus_addr, bus_wdata  out  32 each.
REQ-010 SHALL have ports bus_addr_ok, bus_data_ok  in  1 each, and bus_rdata  in  32.
REQ-011 SHALL have ports stall_request  out  1, load_valid  out  1, and load_data  out  32.

Function
REQ-012 SHALL implement the states IDLE, REQ, WAIT, DONE and CANCEL.
REQ-013 An access SHALL be present when (mem_read_flag | mem_write_flag) & ~flush.
REQ-014 IDLE: when an access is present, SHALL latch addr, sel, wdata, wr and sign_ext, then go to REQ; stall_request SHALL be asserted combinationally in that same cycle.
REQ-015 REQ: bus_req SHALL be 1 and the bus fields SHALL be driven from the latches, held stable until bus_addr_ok.
REQ-016 REQ leaving on bus_addr_ok alone SHALL go to WAIT.
REQ-017 REQ with bus_addr_ok and bus_data_ok in the same cycle SHALL go directly to DONE.
REQ-018 WAIT: bus_req SHALL be 0; on bus_data_ok SHALL capture bus_rdata and go to DONE.
REQ-019 stall_request SHALL be 1 throughout REQ and WAIT.
REQ-020 DONE: stall_request SHALL be 0 and load_valid SHALL be 1; load_valid stays 0 for stores.
REQ-021 DONE SHALL hold while stall_current_stage=1, go to IDLE when it is 0, and never reissue the access.
REQ-022 Minimum read latency: request at cycle 0, addr_ok and data_ok at cycle 1, load_valid at cycle 2.
REQ-023 load_data SHALL be the captured word shifted right by 8*mem_addr[1:0], then sign- or zero-extended from 8/16 bits per sel and sign_ext; word accesses pass unchanged.
REQ-024 flush in IDLE or DONE SHALL go to IDLE with no access issued.
REQ-025 flush in REQ before bus_addr_ok SHALL go to IDLE and drop bus_req the next cycle.
REQ-026 flush in REQ coincident with bus_addr_ok, or in WAIT, SHALL go to CANCEL.
REQ-027 CANCEL SHALL wait for bus_data_ok, discard the data, then go to IDLE.
REQ-028 In CANCEL, stall_request SHALL be 1 only if a new access is present.
REQ-029 bus_wdata SHALL be 0 for reads.
REQ-030 bus_be SHALL equal the latched sel for both reads and writes.

Reset
REQ-031 While rst=0 the block SHALL be in IDLE.
REQ-032 While rst=0 all latches and captured data SHALL be 0.
REQ-033 While rst=0 bus_req, bus_wr, stall_request and load_valid SHALL be 0, and bus_be, bus_addr, bus_wdata and load_data SHALL be 0.
REQ-034 Reset mid-access SHALL abandon the transaction; the bus slave is reset by the same rst.

Structure
REQ-035 The state encoding, the sel lane codes and the 32-bit data/address widths SHALL reside in the shared bus define header.
REQ-036 Load alignment and extension SHALL be one combinational sub-module, load_extend.

Verification
REQ-037 Word load at 0x0000_1000, addr_ok and data_ok at cycle 1, rdata 0xDEADBEEF -> load_valid at cycle 2, load_data 0xDEADBEEF, stall_request high for exactly cycles 0-1.
REQ-038 Signed byte load, addr 0x...03, sel 1000, rdata 0x80xxxxxx -> load_data 0xFFFFFF80; the same with sign_ext=0 -> 0x00000080.
REQ-039 Halfword store, addr 0x...02, sel 1100, addr_ok delayed 3 cycles -> bus_req, bus_addr, bus_be=1100 and bus_wr=1 stable for 4 cycles, load_valid stays 0.
REQ-040 Flush in WAIT, data_ok 2 cycles later, new load present -> stall held through CANCEL, stale data discarded, new request issued the cycle after CANCEL exits.
REQ-041 DONE with stall_current_stage=1 for 5 cycles -> exactly one bus_req handshake, load_valid and load_data held constant for all 5 cycles.
REQ-042 rst driven low in REQ -> all outputs 0 immediately (asynchronously), state IDLE after rst returns high.
